// File: rtl/async_fifo_lvl.sv
// async_fifo_lvl: dual-clock FWFT FIFO with gray-pointer crossing, registered flags and per-domain fill estimates
module async_fifo_lvl #(
    parameter int DSIZE       = 8,
    parameter int ASIZE       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LVL   = 12,
    parameter int AEMPTY_LVL  = 2
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             woverflow,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   rlevel,
    output logic             runderflow
);
    localparam int DEPTH = 1 << ASIZE;
    typedef logic [ASIZE:0] ptr_t;

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [DSIZE-1:0] mem_q [DEPTH];
    ptr_t wbin_q, wbin_d, wgray_q, wgray_d, rsync_bin, wlevel_q, wlevel_d;
    ptr_t rbin_q, rbin_d, rgray_q, rgray_d, wsync_bin, rlevel_q, rlevel_d;
    ptr_t rsync_q [SYNC_STAGES];
    ptr_t wsync_q [SYNC_STAGES];
    logic wfull_q, wfull_d, walmost_full_q, walmost_full_d, woverflow_q, woverflow_d;
    logic rempty_q, rempty_d, ralmost_empty_q, ralmost_empty_d, runderflow_q, runderflow_d;

    always_ff @(posedge wclk) begin
        if (wrst_n && winc && !wfull_q) mem_q[wbin_q[ASIZE-1:0]] <= wdata;
    end

    always_comb begin
        wbin_d         = wbin_q + ptr_t'(winc & ~wfull_q);
        wgray_d        = (wbin_d >> 1) ^ wbin_d;
        rsync_bin      = gray2bin(rsync_q[SYNC_STAGES-1]);
        wlevel_d       = wbin_d - rsync_bin;
        // full when the write pointer has lapped the read pointer exactly once
        wfull_d        = wgray_d == {~rsync_q[SYNC_STAGES-1][ASIZE -: 2], rsync_q[SYNC_STAGES-1][ASIZE-2:0]};
        walmost_full_d = wlevel_d >= ptr_t'(AFULL_LVL);
        woverflow_d    = woverflow_q | (winc & wfull_q);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q         <= '0;
            wgray_q        <= '0;
            wlevel_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) rsync_q[i] <= '0;
        end else begin
            wbin_q         <= wbin_d;
            wgray_q        <= wgray_d;
            wlevel_q       <= wlevel_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
            rsync_q[0]     <= rgray_q;
            for (int i = 1; i < SYNC_STAGES; i++) rsync_q[i] <= rsync_q[i-1];
        end
    end

    always_comb begin
        rbin_d          = rbin_q + ptr_t'(rinc & ~rempty_q);
        rgray_d         = (rbin_d >> 1) ^ rbin_d;
        wsync_bin       = gray2bin(wsync_q[SYNC_STAGES-1]);
        rlevel_d        = wsync_bin - rbin_d;
        rempty_d        = rgray_d == wsync_q[SYNC_STAGES-1];
        ralmost_empty_d = rlevel_d <= ptr_t'(AEMPTY_LVL);
        runderflow_d    = runderflow_q | (rinc & rempty_q);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q          <= '0;
            rgray_q         <= '0;
            rlevel_q        <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            runderflow_q    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) wsync_q[i] <= '0;
        end else begin
            rbin_q          <= rbin_d;
            rgray_q         <= rgray_d;
            rlevel_q        <= rlevel_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            runderflow_q    <= runderflow_d;
            wsync_q[0]      <= wgray_q;
            for (int i = 1; i < SYNC_STAGES; i++) wsync_q[i] <= wsync_q[i-1];
        end
    end

    assign rdata         = mem_q[rbin_q[ASIZE-1:0]];
    assign wfull         = wfull_q;
    assign walmost_full  = walmost_full_q;
    assign wlevel        = wlevel_q;
    assign woverflow     = woverflow_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign rlevel        = rlevel_q;
    assign runderflow    = runderflow_q;
endmodule

// File: tb/tb_async_fifo_lvl.sv
// tb_async_fifo_lvl: directed and randomized checks of async_fifo_lvl with default parameters
module tb_async_fifo_lvl;
    logic       wclk = 1'b0, rclk = 1'b0;
    logic       wrst_n, rrst_n, winc, rinc;
    logic [7:0] wdata, rdata;
    logic       wfull, walmost_full, woverflow, rempty, ralmost_empty, runderflow;
    logic [4:0] wlevel, rlevel;
    int         wh = 5, rh = 14;
    int         passed = 0, total = 0, wcnt = 0, rcnt = 0;
    logic [7:0] sb [$];

    always #(wh) wclk = ~wclk;
    always #(rh) rclk = ~rclk;

    async_fifo_lvl dut (
        .wclk(wclk), .wrst_n(wrst_n), .rclk(rclk), .rrst_n(rrst_n),
        .winc(winc), .wdata(wdata), .wfull(wfull), .walmost_full(walmost_full),
        .wlevel(wlevel), .woverflow(woverflow),
        .rinc(rinc), .rdata(rdata), .rempty(rempty), .ralmost_empty(ralmost_empty),
        .rlevel(rlevel), .runderflow(runderflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [7:0] d);
        @(negedge wclk);
        winc  = 1'b1;
        wdata = d;
        @(posedge wclk);
        #1 winc = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] exp);
        @(negedge rclk);
        check(tag, 32'(rdata), 32'(exp));
        rinc = 1'b1;
        @(posedge rclk);
        #1 rinc = 1'b0;
    endtask

    task automatic wait_nonempty(input string tag);
        for (int n = 0; n < 20; n++) begin
            @(posedge rclk);
            #1;
            if (!rempty) break;
        end
        check(tag, 32'(rempty), 0);
    endtask

    task automatic wr_rand();
        int  wn = 0;
        logic done = 1'b0;
        winc = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(posedge wclk);
            #1;
            if (winc) wcnt++;
            check("wlevel_bound", 32'(int'(wlevel) >= wcnt - rcnt && wlevel <= 5'd16), 1);
            if (wn == 1000) begin
                winc = 1'b0;
                done = 1'b1;
            end else begin
                winc = $urandom_range(0, 1) == 1 && !wfull;
                if (winc) begin
                    wdata = 8'($urandom);
                    sb.push_back(wdata);
                    wn++;
                end
            end
        end
        check("wr_rand_done", 32'(done), 1);
    endtask

    task automatic rd_rand();
        int  rn = 0;
        logic done = 1'b0;
        rinc = 1'b0;
        for (int c = 0; c < 40000 && !done; c++) begin
            @(posedge rclk);
            #1;
            if (rinc) rcnt++;
            check("rlevel_bound", 32'(int'(rlevel) <= wcnt - rcnt), 1);
            if (rn == 1000) begin
                rinc = 1'b0;
                done = 1'b1;
            end else begin
                rinc = $urandom_range(0, 1) == 1 && !rempty;
                if (rinc) begin
                    check("rand_data", 32'(rdata), 32'(sb.size() > 0 ? sb.pop_front() : 8'hxx));
                    rn++;
                end
            end
        end
        check("rd_rand_done", 32'(done), 1);
    endtask

    initial begin
        wrst_n = 1'b0; rrst_n = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
        #30;
        check("rst_wfull", 32'(wfull), 0);
        check("rst_walmost_full", 32'(walmost_full), 0);
        check("rst_wlevel", 32'(wlevel), 0);
        check("rst_woverflow", 32'(woverflow), 0);
        check("rst_rempty", 32'(rempty), 1);
        check("rst_ralmost_empty", 32'(ralmost_empty), 1);
        check("rst_rlevel", 32'(rlevel), 0);
        check("rst_runderflow", 32'(runderflow), 0);
        wrst_n = 1'b1; rrst_n = 1'b1;
        repeat (3) @(posedge rclk);

        // five words; empty must clear on the third rclk edge after the first write
        @(posedge rclk);
        #1;
        fork
            for (int i = 1; i <= 5; i++) wr(8'(i));
            begin
                int n;
                n = 0;
                do @(posedge wclk); while (!winc);
                while (n < 10) begin
                    @(posedge rclk);
                    n++;
                    #1;
                    if (!rempty) break;
                end
                check("rempty_fall_edges", 32'(n), 3);
            end
        join
        check("wlevel_5", 32'(wlevel), 5);
        repeat (6) @(posedge rclk);
        #1;
        check("rlevel_5", 32'(rlevel), 5);
        check("ralmost_empty_5", 32'(ralmost_empty), 0);
        for (int i = 1; i <= 5; i++) begin
            rd("rd_seq", 8'(i));
            check("rempty_seq", 32'(rempty), 32'(i == 5));
            check("ralmost_empty_seq", 32'(ralmost_empty), 32'(i >= 3));
        end
        repeat (6) @(posedge wclk);
        #1;
        check("wlevel_drained", 32'(wlevel), 0);

        // fill to full, then one overflowing request
        for (int i = 1; i <= 16; i++) begin
            wr(8'(8'h0f + i));
            check("fill_wlevel", 32'(wlevel), 32'(i));
            check("fill_walmost_full", 32'(walmost_full), 32'(i >= 12));
            check("fill_wfull", 32'(wfull), 32'(i == 16));
        end
        check("woverflow_pre", 32'(woverflow), 0);
        wr(8'hee);
        check("woverflow_set", 32'(woverflow), 1);
        check("wfull_hold", 32'(wfull), 1);
        check("wlevel_hold", 32'(wlevel), 16);
        repeat (5) @(posedge rclk);
        #1;
        check("rlevel_full", 32'(rlevel), 16);
        for (int i = 0; i < 16; i++) rd("rd_full", 8'(8'h10 + i));
        check("rempty_after_full", 32'(rempty), 1);

        // read on empty
        @(negedge rclk);
        rinc = 1'b1;
        @(posedge rclk);
        #1 rinc = 1'b0;
        check("runderflow_set", 32'(runderflow), 1);
        check("rempty_underflow", 32'(rempty), 1);
        check("rlevel_underflow", 32'(rlevel), 0);
        wr(8'ha5);
        wait_nonempty("ne_after_underflow");
        rd("rd_after_underflow", 8'ha5);
        check("woverflow_sticky", 32'(woverflow), 1);
        check("runderflow_sticky", 32'(runderflow), 1);

        // write/read pairs walking the pointers across the wrap
        for (int i = 0; i < 40; i++) begin
            wr(8'(8'h40 + i));
            check("wrap_wfull", 32'(wfull), 0);
            wait_nonempty("wrap_nonempty");
            rd("wrap_data", 8'(8'h40 + i));
        end
        repeat (6) @(posedge wclk);
        #1;
        check("wrap_wlevel", 32'(wlevel), 0);
        check("wrap_rempty", 32'(rempty), 1);

        // fill to ten, then reset both domains together
        for (int i = 0; i < 10; i++) wr(8'(8'h60 + i));
        check("ten_wlevel", 32'(wlevel), 10);
        repeat (2) @(posedge rclk);
        wrst_n = 1'b0; rrst_n = 1'b0;
        #20;
        check("mid_rst_wlevel", 32'(wlevel), 0);
        check("mid_rst_woverflow", 32'(woverflow), 0);
        check("mid_rst_rempty", 32'(rempty), 1);
        check("mid_rst_ralmost_empty", 32'(ralmost_empty), 1);
        check("mid_rst_runderflow", 32'(runderflow), 0);
        wrst_n = 1'b1; rrst_n = 1'b1;
        repeat (5) @(posedge rclk);
        #1;
        check("post_rst_rempty", 32'(rempty), 1);
        check("post_rst_rlevel", 32'(rlevel), 0);
        check("post_rst_wlevel", 32'(wlevel), 0);
        wr(8'h5a);
        wait_nonempty("post_rst_nonempty");
        rd("post_rst_first", 8'h5a);
        repeat (6) @(posedge wclk);

        // random traffic, fast writer then fast reader
        wcnt = 0; rcnt = 0;
        fork
            wr_rand();
            rd_rand();
        join
        wh = 14; rh = 5;
        repeat (10) @(posedge wclk);
        wcnt = 0; rcnt = 0;
        fork
            wr_rand();
            rd_rand();
        join
        repeat (10) @(posedge wclk);
        #1;
        check("rand_woverflow", 32'(woverflow), 0);
        check("rand_runderflow", 32'(runderflow), 0);
        check("rand_rempty", 32'(rempty), 1);
        check("rand_wlevel", 32'(wlevel), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
